// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the digit count, segment-off pattern, glyph codes, the slot-index
// type, the scan FSM state encoding and the leading-zero mask helper.
package seg7_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;
  localparam logic [3:0]  GLYPH_E    = 4'hE;
  localparam logic [3:0]  GLYPH_F    = 4'hF;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    RUN   = 1'b1
  } scan_state_e;

  // Leading-zero blank mask: walk from thousands downward, blanking zero
  // digits until the first nonzero one. The ones digit is never blanked so
  // a value of zero still shows a single "0".
  function automatic logic [3:0] lz_mask(input logic [15:0] digits);
    logic [3:0] mask;
    logic       leading;
    mask    = 4'h0;
    leading = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      if (leading && (digits[k*4 +: 4] == 4'h0)) begin
        mask[k] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seven_segment.sv
// Hex-digit to seven-segment decoder, active-low, bit order {g,f,e,d,c,b,a}.
// Numerals 0-9 and the E/F glyphs are defined; every other code is dark.
module seven_segment
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Combinational code-to-segment lookup.
  always_comb begin
    seg_o = SEG_OFF;
    case (digit_i)
      4'h0:    seg_o = 7'h40;
      4'h1:    seg_o = 7'h79;
      4'h2:    seg_o = 7'h24;
      4'h3:    seg_o = 7'h30;
      4'h4:    seg_o = 7'h19;
      4'h5:    seg_o = 7'h12;
      4'h6:    seg_o = 7'h02;
      4'h7:    seg_o = 7'h78;
      4'h8:    seg_o = 7'h00;
      4'h9:    seg_o = 7'h10;
      GLYPH_E: seg_o = 7'h06;
      GLYPH_F: seg_o = 7'h0E;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan controller.
// A new value is accepted into a shadow register over valid/ready and only
// copied into the active register at a frame boundary, so the display never
// shows a half-updated value. Build option: define SEG7_LZ_BLANK_EN to add
// automatic leading-zero blanking at commit time.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_digits,
  input  logic [3:0]  load_blank,
  output logic [6:0]  seg7,
  output logic [3:0]  digit_en_n,
  output logic        frame_done
);

  localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam int            DW      = 4 * NUM_DIGITS;

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  scan_state_e   state_q, state_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] shadow_digits_q, shadow_digits_d;
  logic [3:0]    shadow_blank_q, shadow_blank_d;
  logic [DW-1:0] active_digits_q, active_digits_d;
  logic [3:0]    active_blank_q, active_blank_d;
  logic [6:0]    seg7_q, seg7_d;
  logic [3:0]    digit_en_n_q, digit_en_n_d;
  logic          frame_done_q;

  logic          tick_s, frame_end_s, commit_s, xfer_s;
  logic [3:0]    commit_blank_s;
  logic [3:0]    dec_digit_s;
  logic [6:0]    dec_seg_s;

  assign tick_s      = (cnt_q == CNT_MAX);
  assign frame_end_s = tick_s && (idx_q == 2'd3);
  assign commit_s    = frame_end_s && pending_q;
  assign xfer_s      = load_valid && !pending_q;
  assign load_ready  = !pending_q;

  // Blank mask that becomes active at commit (optionally with leading zeros).
  always_comb begin
`ifdef SEG7_LZ_BLANK_EN
    commit_blank_s = shadow_blank_q | lz_mask(shadow_digits_q);
`else
    commit_blank_s = shadow_blank_q;
`endif
  end

  // Prescaler and slot index: slot advances on every prescaler wrap.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick_s) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Handshake, shadow capture and frame-boundary commit.
  always_comb begin
    pending_d       = pending_q;
    shadow_digits_d = shadow_digits_q;
    shadow_blank_d  = shadow_blank_q;
    active_digits_d = active_digits_q;
    active_blank_d  = active_blank_q;
    state_d         = state_q;
    if (commit_s) begin
      active_digits_d = shadow_digits_q;
      active_blank_d  = commit_blank_s;
      pending_d       = 1'b0;
      state_d         = RUN;
    end else if (xfer_s) begin
      shadow_digits_d = load_digits;
      shadow_blank_d  = load_blank;
      pending_d       = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // The decoder sees the digit of the slot that will be shown after this edge.
  assign dec_digit_s = active_digits_d[{idx_d, 2'b00} +: 4];

  seven_segment u_dec (
    .digit_i (dec_digit_s),
    .seg_o   (dec_seg_s)
  );

  // Next display pattern: dark while blank or slot forced off, else decoded.
  always_comb begin
    seg7_d       = SEG_OFF;
    digit_en_n_d = 4'hF;
    if ((state_d == RUN) && !active_blank_d[idx_d]) begin
      seg7_d       = dec_seg_s;
      digit_en_n_d = ~(4'b0001 << idx_d);
    end else begin
      seg7_d       = SEG_OFF;
      digit_en_n_d = 4'hF;
    end
  end

  // State, data and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      idx_q           <= 2'd0;
      state_q         <= BLANK;
      pending_q       <= 1'b0;
      shadow_digits_q <= 16'h0000;
      shadow_blank_q  <= 4'h0;
      active_digits_q <= 16'h0000;
      active_blank_q  <= 4'hF;
      seg7_q          <= SEG_OFF;
      digit_en_n_q    <= 4'hF;
      frame_done_q    <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      state_q         <= state_d;
      pending_q       <= pending_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_blank_q  <= shadow_blank_d;
      active_digits_q <= active_digits_d;
      active_blank_q  <= active_blank_d;
      seg7_q          <= seg7_d;
      digit_en_n_q    <= digit_en_n_d;
      frame_done_q    <= frame_end_s;
    end
  end

  assign seg7       = seg7_q;
  assign digit_en_n = digit_en_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with REFRESH_DIV=4.
// A cycle-count reference model runs alongside the DUT; table vectors and
// hand-written sequences cover the frame-boundary corner cases.
module tb_seg7_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_digits = 16'h0000;
  logic [3:0]  load_blank = 4'h0;
  logic [6:0]  seg7;
  logic [3:0]  digit_en_n;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .load_blank  (load_blank),
    .seg7        (seg7),
    .digit_en_n  (digit_en_n),
    .frame_done  (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference segment patterns (active-low, {g,f,e,d,c,b,a}).
  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    case (c)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
      4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
      4'h9: return 7'h10;  4'hE: return 7'h06;  4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] ref_lz(input logic [15:0] d);
    logic [3:0] m;
    m = 4'h0;
`ifdef SEG7_LZ_BLANK_EN
    if (d[15:12] == 4'h0) begin
      m[3] = 1'b1;
      if (d[11:8] == 4'h0) begin
        m[2] = 1'b1;
        if (d[7:4] == 4'h0) m[1] = 1'b1;
      end
    end
`endif
    return m;
  endfunction

  // Reference model: time is the number of clock edges since reset release.
  int unsigned m_edges;
  logic [15:0] m_act_d, m_sh_d;
  logic [3:0]  m_act_b, m_sh_b;
  bit          m_pend, m_run, m_fd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_act_d <= 16'h0000;
      m_act_b <= 4'hF;
      m_sh_d  <= 16'h0000;
      m_sh_b  <= 4'h0;
      m_pend  <= 1'b0;
      m_run   <= 1'b0;
      m_fd    <= 1'b0;
    end else begin
      m_edges <= m_edges + 1;
      m_fd    <= ((m_edges + 1) % FRAME == 0);
      if (((m_edges + 1) % FRAME == 0) && m_pend) begin
        m_act_d <= m_sh_d;
        m_act_b <= m_sh_b | ref_lz(m_sh_d);
        m_pend  <= 1'b0;
        m_run   <= 1'b1;
      end else if (load_valid && !m_pend) begin
        m_sh_d <= load_digits;
        m_sh_b <= load_blank;
        m_pend <= 1'b1;
      end
    end
  end

  function automatic logic [3:0] exp_en();
    int s;
    logic [3:0] one;
    s = (m_edges / DIV) % 4;
    one = 4'b0001;
    if (!m_run || m_act_b[s]) return 4'hF;
    return ~(one << s);
  endfunction

  function automatic logic [6:0] exp_seg();
    int s;
    s = (m_edges / DIV) % 4;
    if (!m_run || m_act_b[s]) return 7'h7F;
    return ref_seg(m_act_d[s*4 +: 4]);
  endfunction

  // Continuous comparison of every output against the model.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("model_seg7", {25'd0, seg7}, {25'd0, exp_seg()});
      check("model_digit_en_n", {28'd0, digit_en_n}, {28'd0, exp_en()});
      check("model_frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      check("model_load_ready", {31'd0, load_ready}, {31'd0, !m_pend});
    end
  end

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [27:0] seg_all;   // {slot3, slot2, slot1, slot0}
    logic [15:0] en_all;    // {slot3, slot2, slot1, slot0}
  } vec_t;

  vec_t vecs [5];

  task automatic load_value(input logic [15:0] d, input logic [3:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!load_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!load_ready) check("ready_timeout", 32'd0, 32'd1);
    load_valid  = 1'b1;
    load_digits = d;
    load_blank  = b;
    @(negedge clk);
    load_valid  = 1'b0;
  endtask

  task automatic wait_commit();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (frame_done && load_ready) seen = 1'b1;
    end
    if (!seen) check("commit_timeout", 32'd0, 32'd1);
  endtask

  logic [3:0] codes [12];
  int pulses, lit;
  bit found;

  initial begin
    codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE, 4'hF};

    vecs[0] = '{16'h12EF, 4'h0, {7'h79, 7'h24, 7'h06, 7'h0E}, 16'h7BDE};
`ifdef SEG7_LZ_BLANK_EN
    vecs[1] = '{16'h0040, 4'h0, {7'h7F, 7'h7F, 7'h19, 7'h40}, 16'hFFDE};
    vecs[3] = '{16'h0000, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 16'hFFFE};
`else
    vecs[1] = '{16'h0040, 4'h0, {7'h40, 7'h40, 7'h19, 7'h40}, 16'h7BDE};
    vecs[3] = '{16'h0000, 4'h0, {7'h40, 7'h40, 7'h40, 7'h40}, 16'h7BDE};
`endif
    vecs[2] = '{16'h9876, 4'h5, {7'h10, 7'h7F, 7'h78, 7'h7F}, 16'h7FDF};
    vecs[4] = '{16'h3535, 4'h8, {7'h7F, 7'h12, 7'h30, 7'h12}, 16'hFBDE};

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check("rst_seg7", {25'd0, seg7}, 32'h7F);
    check("rst_digit_en_n", {28'd0, digit_en_n}, 32'hF);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // No load: dark for 100 cycles, frame_done every 16 cycles.
    pulses = 0;
    lit    = 0;
    repeat (100) begin
      @(negedge clk);
      if (frame_done) pulses++;
      if (digit_en_n != 4'hF || seg7 != 7'h7F) lit++;
    end
    check("idle_frame_pulses", pulses, 32'd6);
    check("idle_lit_cycles", lit, 32'd0);

    // Table vectors: load, wait for commit, walk the four slots.
    for (int i = 0; i < 5; i++) begin
      load_value(vecs[i].digits, vecs[i].blank);
      wait_commit();
      for (int s = 0; s < 4; s++) begin
        check($sformatf("vec%0d_slot%0d_seg7", i, s), {25'd0, seg7}, {25'd0, vecs[i].seg_all[s*7 +: 7]});
        check($sformatf("vec%0d_slot%0d_en", i, s), {28'd0, digit_en_n}, {28'd0, vecs[i].en_all[s*4 +: 4]});
        repeat (DIV) @(negedge clk);
      end
    end

    // Load during pending: second value held until ready returns.
    load_value(16'h1111, 4'h0);
    load_valid  = 1'b1;
    load_digits = 16'h2222;
    check("pend_ready_low", {31'd0, load_ready}, 32'd0);
    wait_commit();
    check("pend_first_seg7", {25'd0, seg7}, 32'h79);
    check("pend_first_en", {28'd0, digit_en_n}, 32'hE);
    @(negedge clk);
    check("pend_second_captured", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    wait_commit();
    check("pend_second_seg7", {25'd0, seg7}, 32'h24);

    // Transfer coincident with frame end: commit one full frame later.
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (((m_edges + 1) % FRAME == 0) && load_ready) found = 1'b1;
    end
    if (!found) check("coinc_align_timeout", 32'd0, 32'd1);
    load_valid  = 1'b1;
    load_digits = 16'h5555;
    load_blank  = 4'h0;
    @(negedge clk);
    load_valid = 1'b0;
    check("coinc_frame_done", {31'd0, frame_done}, 32'd1);
    check("coinc_ready_low", {31'd0, load_ready}, 32'd0);
    check("coinc_old_value", {25'd0, seg7}, 32'h24);
    repeat (FRAME - 1) @(negedge clk);
    check("coinc_not_yet", {31'd0, load_ready}, 32'd0);
    @(negedge clk);
    check("coinc_commit_fd", {31'd0, frame_done}, 32'd1);
    check("coinc_commit_ready", {31'd0, load_ready}, 32'd1);
    check("coinc_commit_seg7", {25'd0, seg7}, 32'h12);

    // Reset mid-frame while a value is pending.
    load_value(16'h7777, 4'h0);
    repeat (4) @(negedge clk);
    check("rstmid_pending", {31'd0, load_ready}, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("rstmid_seg7", {25'd0, seg7}, 32'h7F);
    check("rstmid_en", {28'd0, digit_en_n}, 32'hF);
    check("rstmid_ready", {31'd0, load_ready}, 32'd1);
    check("rstmid_fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lit = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (digit_en_n != 4'hF) lit++;
    end
    check("rstmid_shadow_dropped", lit, 32'd0);

    // Randomized traffic against the model.
    repeat (800) begin
      @(negedge clk);
      load_valid = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) load_digits[k*4 +: 4] = codes[$urandom_range(0, 11)];
      load_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
    end
    load_valid = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
